// File: rtl/div_ctrl_pkg.sv
// Shared configuration for the multi-cycle divide unit: state encodings,
// default widths and the decoder's DIV/DIVU alucontrol codes.
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider datapath: operand magnitudes, partial remainder,
// quotient shift register, iteration counter and sign fix-up.
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    // qd_r starts as the dividend magnitude; quotient bits shift in at the LSB
    logic [WIDTH-1:0] qd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sign_q_r;
    logic             sign_r_r;

    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   shift_s;
    logic             ge_s;
    logic [WIDTH-1:0] sub_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] qd_nxt_s;

    // Operand magnitudes, one trial subtraction and the sign-corrected result
    always_comb begin
        neg_a_s  = is_signed & a[WIDTH-1];
        neg_b_s  = is_signed & b[WIDTH-1];
        mag_a_s  = neg_a_s ? -a : a;
        mag_b_s  = neg_b_s ? -b : b;
        shift_s  = {rem_r, qd_r[WIDTH-1]};
        ge_s     = (shift_s >= {1'b0, dvs_r});
        // The true difference is below 2^WIDTH whenever it is kept
        sub_s    = shift_s[WIDTH-1:0] - dvs_r;
        if (ge_s) begin
            rem_nxt_s = sub_s;
        end else begin
            rem_nxt_s = shift_s[WIDTH-1:0];
        end
        qd_nxt_s = {qd_r[WIDTH-2:0], ge_s};
        quo_o    = sign_q_r ? -qd_nxt_s : qd_nxt_s;
        rem_o    = sign_r_r ? -rem_nxt_s : rem_nxt_s;
        last_o   = (cnt_r == CNT_W'(WIDTH-1));
    end

    // Operand capture on launch, then one quotient bit per step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qd_r     <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
        end else if (load) begin
            qd_r     <= mag_a_s;
            dvs_r    <= mag_b_s;
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            sign_q_r <= neg_a_s ^ neg_b_s;
            sign_r_r <= neg_a_s;
        end else if (step) begin
            qd_r     <= qd_nxt_s;
            rem_r    <= rem_nxt_s;
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU controller beside the EX-stage ALU: stalls the pipeline while
// div_core iterates, then holds LO/HI until EX acknowledges; flush cancels.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             ack,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             dz_o
);

    div_state_t       state_r;
    logic             accept_s;
    logic             step_s;
    logic             b_zero_s;
    logic             last_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Launch/step qualification and the combinational stall request
    always_comb begin
        accept_s = (state_r == DIV_IDLE) & start & ~flush;
        step_s   = (state_r == DIV_BUSY) & ~flush;
        b_zero_s = (b == {WIDTH{1'b0}});
        stall_o  = resetn & (accept_s | (state_r == DIV_BUSY));
    end

    div_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept_s),
        .step      (step_s),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .last_o    (last_s),
        .quo_o     (quo_s),
        .rem_o     (rem_s)
    );

    // Controller FSM with registered result outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
            lo_o    <= {WIDTH{1'b0}};
            hi_o    <= {WIDTH{1'b0}};
            dz_o    <= 1'b0;
            valid_o <= 1'b0;
        end else if (flush) begin
            state_r <= DIV_IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        dz_o <= b_zero_s;
                        if (b_zero_s) begin
                            lo_o    <= {WIDTH{1'b1}};
                            hi_o    <= a;
                            valid_o <= 1'b1;
                            state_r <= DIV_DONE;
                        end else begin
                            state_r <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (last_s) begin
                        lo_o    <= quo_s;
                        hi_o    <= rem_s;
                        valid_o <= 1'b1;
                        state_r <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // A start still held here is taken only after returning to IDLE
                    if (ack) begin
                        valid_o <= 1'b0;
                        state_r <= DIV_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
